// File: rtl/picorv32_pcpi_arb.sv
// PCPI arbiter: routes RV32M instructions from the core to a multiplier or a
// divider coprocessor, and rejects anything else with a timeout pulse.
module picorv32_pcpi_arb #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        pcpi_timeout,
  output logic [31:0] cp_insn,
  output logic [31:0] cp_rs1,
  output logic [31:0] cp_rs2,
  output logic        mul_valid,
  output logic        div_valid,
  input  logic        mul_wr,
  input  logic        mul_wait,
  input  logic        mul_ready,
  input  logic [31:0] mul_rd,
  input  logic        div_wr,
  input  logic        div_wait,
  input  logic        div_ready,
  input  logic [31:0] div_rd
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, REJECT, DONE} state_e;

  state_e      state_q, state_d;
  logic        tgt_q, tgt_d;
  logic        seen_wait_q, seen_wait_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic        ready_q, ready_d, timeout_q, timeout_d, wr_q, wr_d, wait_q, wait_d;
  logic [31:0] rd_q, rd_d;

  logic        is_m;
  logic        sel_wait, sel_ready, sel_wr;
  logic [31:0] sel_rd;

  assign is_m      = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
  assign sel_wait  = tgt_q ? div_wait  : mul_wait;
  assign sel_ready = tgt_q ? div_ready : mul_ready;
  assign sel_wr    = tgt_q ? div_wr    : mul_wr;
  assign sel_rd    = tgt_q ? div_rd    : mul_rd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      tgt_q       <= 1'b0;
      seen_wait_q <= 1'b0;
      cnt_q       <= '0;
      insn_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      ready_q     <= 1'b0;
      timeout_q   <= 1'b0;
      wr_q        <= 1'b0;
      wait_q      <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      seen_wait_q <= seen_wait_d;
      cnt_q       <= cnt_d;
      insn_q      <= insn_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      ready_q     <= ready_d;
      timeout_q   <= timeout_d;
      wr_q        <= wr_d;
      wait_q      <= wait_d;
      rd_q        <= rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    seen_wait_d = seen_wait_q;
    cnt_d       = cnt_q;
    insn_d      = insn_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    ready_d     = 1'b0;
    timeout_d   = 1'b0;
    wr_d        = 1'b0;
    wait_d      = 1'b0;
    rd_d        = rd_q;
    case (state_q)
      IDLE: begin
        if (pcpi_valid) begin
          insn_d      = pcpi_insn;
          rs1_d       = pcpi_rs1;
          rs2_d       = pcpi_rs2;
          tgt_d       = pcpi_insn[14];
          cnt_d       = '0;
          seen_wait_d = 1'b0;
          state_d     = is_m ? ISSUE : REJECT;
        end
      end
      ISSUE: begin
        // Abort wins over a coincident ready; once wait is seen the clock stops.
        if (!pcpi_valid) begin
          state_d = IDLE;
        end else if (sel_ready) begin
          state_d = DONE;
          ready_d = 1'b1;
          wr_d    = sel_wr;
          rd_d    = sel_rd;
        end else if (sel_wait) begin
          seen_wait_d = 1'b1;
        end else if (!seen_wait_q) begin
          if (cnt_q == CNT_LAST) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        wait_d = (state_d == ISSUE) && sel_wait;
      end
      REJECT: begin
        if (!pcpi_valid) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else if (!(&cnt_q)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (!pcpi_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_valid    = (state_q == ISSUE) && !tgt_q;
    div_valid    = (state_q == ISSUE) && tgt_q;
    cp_insn      = insn_q;
    cp_rs1       = rs1_q;
    cp_rs2       = rs2_q;
    pcpi_ready   = ready_q;
    pcpi_timeout = timeout_q;
    pcpi_wr      = wr_q;
    pcpi_rd      = rd_q;
    pcpi_wait    = wait_q;
  end
endmodule

// File: doc/picorv32_pcpi_arb.md
PICORV32_PCPI_ARB -- requirements
Module: picorv32_pcpi_arb

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the cycles allowed between issue and first coprocessor wait/ready before rejection.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: ports clk and resetn.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 pcpi_valid  input  1  core request valid, held until pcpi_ready or pcpi_timeout.
REQ-006 pcpi_insn / pcpi_rs1 / pcpi_rs2  input  32 each  core instruction and operands.
REQ-007 pcpi_wr  output  1  result valid for register write.
REQ-008 pcpi_rd  output  32  result data.
REQ-009 pcpi_wait  output  1  selected coprocessor busy.
REQ-010 pcpi_ready  output  1  one-cycle completion pulse.
REQ-011 pcpi_timeout  output  1  one-cycle pulse: instruction not accepted (illegal).
REQ-012 cp_insn / cp_rs1 / cp_rs2  output  32 each  registered operands shared by both coprocessors.
REQ-013 mul_valid, div_valid  output  1 each  per-coprocessor request valid.
REQ-014 mul_wr, mul_wait, mul_ready (1 each), mul_rd (32)  input  multiplier response.
REQ-015 div_wr, div_wait, div_ready (1 each), div_rd (32)  input  divider response.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, REJECT, DONE.
REQ-017 IDLE: on pcpi_valid, latch insn/rs1/rs2 into cp_*, clear timeout counter, go ISSUE if insn[6:0]=0110011 and insn[31:25]=0000001, else REJECT.
REQ-018 Target selection: insn[14] = 0 -> multiplier, 1 -> divider; target latched at issue, fixed until IDLE.
REQ-019 ISSUE: selected *_valid SHALL be 1 starting the cycle after latch; other *_valid SHALL be 0; never both high.
REQ-020 pcpi_wait SHALL be the registered selected *_wait (one-cycle delay), 0 outside ISSUE.
REQ-021 ISSUE: counter increments each cycle while selected wait and ready both low; at count = TIMEOUT-1 pulse pcpi_timeout for 1 cycle, drop *_valid, go DONE.
REQ-022 Once selected wait has been seen high, timeout counting SHALL stop for that instruction.
REQ-023 On selected *_ready in ISSUE: next cycle pcpi_ready=1, pcpi_wr=selected *_wr, pcpi_rd=selected *_rd, *_valid=0, go DONE.
REQ-024 ready/wr/rd of the non-selected coprocessor SHALL be ignored, including when simultaneous with selected ready.
REQ-025 REJECT: count TIMEOUT cycles from latch, then pulse pcpi_timeout, go DONE; no *_valid asserted.
REQ-026 DONE: go IDLE when pcpi_valid=0; no new request accepted while pcpi_valid stays high.
REQ-027 pcpi_valid falling in ISSUE or REJECT (abort) SHALL return to IDLE next cycle with *_valid=0 and no ready/timeout pulse.
REQ-028 pcpi_ready and pcpi_timeout SHALL never assert in the same cycle; each SHALL be exactly one cycle wide.
REQ-029 pcpi_rd SHALL hold the last result when pcpi_ready=0; pcpi_wr SHALL be 0 when pcpi_ready=0.
REQ-030 Counter SHALL be $clog2(TIMEOUT)+1 bits and SHALL saturate, never wrap.

Reset
REQ-031 resetn=0 SHALL immediately force: state IDLE, all *_valid, pcpi_wr, pcpi_wait, pcpi_ready, pcpi_timeout = 0, pcpi_rd and cp_* = 0, counter 0.
REQ-032 Reset asserted mid-operation SHALL abort without a ready or timeout pulse; late coprocessor responses after reset SHALL be ignored until a new issue.

Verification
REQ-033 DIVU issue: insn funct3=101, rs1=100, rs2=7, divider model returns ready with rd=14 after 34 cycles -> div_valid only, pcpi_wait high, one pcpi_ready with pcpi_rd=14, pcpi_wr=1.
REQ-034 MUL issue: funct3=000, rs1=6, rs2=7, mul ready rd=42 -> mul_valid only, pcpi_rd=42 one cycle after mul_ready.
REQ-035 Non-M insn 0x00000033 (ADD) -> no *_valid, pcpi_timeout pulses 16 cycles after latch, no pcpi_ready.
REQ-036 DIV issued, divider never waits/readies -> pcpi_timeout pulse at TIMEOUT, div_valid dropped same cycle.
REQ-037 Simultaneous mul_ready (rd=0xDEAD) and div_ready (rd=3) during div op -> pcpi_rd=3.
REQ-038 resetn low 20 cycles into a divide, then div_ready arrives -> all outputs 0, no pcpi_ready; next request completes normally.
